calc_key_seq: RTL and testbench

CALC_KEY_SEQ -- requirements
Module: calc_key_seq

---
 rtl/calc_pkg.sv | 26 ++
 rtl/bcd_addsub_unit.sv | 52 +++++
 rtl/calc_key_seq.sv | 193 +++++++++++++++++++
 tb/tb_calc_key_seq.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// calc_pkg -- shared definitions for the calculator key sequencer.
//   calc_state_e   : FSM state encoding (S_LEFT, S_OP, S_RIGHT, S_CALC, S_SHOW)
//   KEY_*          : key code constants
//   BLANK_CODE_DEF : default digit code for blanked display positions
//   is_digit()     : true for key codes 0-9
package calc_pkg;

  typedef enum logic [2:0] {
    S_LEFT  = 3'd0,
    S_OP    = 3'd1,
    S_RIGHT = 3'd2,
    S_CALC  = 3'd3,
    S_SHOW  = 3'd4
  } calc_state_e;

  localparam logic [3:0] KEY_ADD        = 4'hA;
  localparam logic [3:0] KEY_SUB        = 4'hB;
  localparam logic [3:0] KEY_ENTER      = 4'hC;
  localparam logic [3:0] KEY_CLR        = 4'hD;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;

  function automatic logic is_digit(input logic [3:0] code);
    return (code < 4'd10);
  endfunction

endpackage

// File: rtl/bcd_addsub_unit.sv
// bcd_addsub_unit -- combinational single-digit add/subtract with a
// two-digit BCD result.
//   a, b   : operands, 0-9 each
//   op_sub : 1 = subtract (a-b), 0 = add
//   tens   : result tens digit (0 or 1)
//   ones   : result ones digit
//   neg    : result is a negative magnitude
// Optional feature macro: CALC_SUB_EN (subtract path). Without it only the
// adder is built and neg is constant 0.
module bcd_addsub_unit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       op_sub,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       neg
);

  logic [4:0] mag_s;

`ifndef CALC_SUB_EN
  logic unused_op_s;
  assign unused_op_s = op_sub;
`endif

  // Magnitude and sign, then split magnitude (max 18) into tens/ones.
  always_comb begin
    mag_s = {1'b0, a} + {1'b0, b};
    neg   = 1'b0;
`ifdef CALC_SUB_EN
    if (op_sub) begin
      if (b > a) begin
        mag_s = {1'b0, b - a};
        neg   = 1'b1;
      end else begin
        mag_s = {1'b0, a - b};
        neg   = 1'b0;
      end
    end else begin
      neg = 1'b0;
    end
`endif
    if (mag_s >= 5'd10) begin
      tens = 4'd1;
      ones = 4'(mag_s - 5'd10);
    end else begin
      tens = 4'd0;
      ones = mag_s[3:0];
    end
  end

endmodule

// File: rtl/calc_key_seq.sv
// calc_key_seq -- key sequencer for a single-digit two-operand calculator.
//   clk, rst_n           : clock, async active-low reset
//   key_valid/key_code   : key strobe and code (0-9, A add, B sub, C enter, D clear)
//   key_ready            : key accepted when key_valid && key_ready
//   disp                 : {left, right, result tens, result ones}, blanked
//                          positions carry BLANK_CODE
//   neg                  : result sign
//   busy                 : high during the one-cycle S_CALC state
// Optional feature macro: CALC_SUB_EN (honour the subtract key). When
// undefined, 4'hB is a reserved code and neg is tied low.
// The display register is loaded from the current state registers, so it
// trails the state by one cycle: result appears two edges after enter.
module calc_key_seq
  import calc_pkg::*;
#(
  parameter logic [3:0]  BLANK_CODE = BLANK_CODE_DEF,
  parameter int unsigned KEY_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_valid,
  input  logic [KEY_W-1:0] key_code,
  output logic             key_ready,
  output logic [15:0]      disp,
  output logic             neg,
  output logic             busy
);

  calc_state_e state_q, state_d;
  logic [3:0]  left_q, left_d, right_q, right_d;
  logic [3:0]  tens_q, tens_d, ones_q, ones_d;
  logic        op_sub_q, op_sub_d, neg_q, neg_d, right_vld_q, right_vld_d;
  logic        key_ready_q, busy_q;
  logic [15:0] disp_q, disp_d;
  logic [3:0]  au_tens_s, au_ones_s;
  logic        au_neg_s;
  logic        accept_s, key_digit_s, key_add_s, key_sub_s, key_enter_s, key_clr_s;

  assign accept_s    = key_valid && key_ready_q;
  assign key_digit_s = is_digit(key_code[3:0]) && (key_code < KEY_W'(10));
  assign key_add_s   = (key_code == KEY_W'(KEY_ADD));
  assign key_enter_s = (key_code == KEY_W'(KEY_ENTER));
  assign key_clr_s   = (key_code == KEY_W'(KEY_CLR));
`ifdef CALC_SUB_EN
  assign key_sub_s   = (key_code == KEY_W'(KEY_SUB));
  assign neg         = neg_q;
`else
  assign key_sub_s   = 1'b0;
  assign neg         = 1'b0;
`endif

  bcd_addsub_unit u_addsub (
    .a      (left_q),
    .b      (right_q),
    .op_sub (op_sub_q),
    .tens   (au_tens_s),
    .ones   (au_ones_s),
    .neg    (au_neg_s)
  );

  // Next-state and datapath update from the accepted key.
  always_comb begin
    state_d     = state_q;
    left_d      = left_q;
    right_d     = right_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    op_sub_d    = op_sub_q;
    neg_d       = neg_q;
    right_vld_d = right_vld_q;
    if (accept_s && key_clr_s) begin
      state_d     = S_LEFT;
      left_d      = 4'd0;
      right_d     = 4'd0;
      tens_d      = 4'd0;
      ones_d      = 4'd0;
      op_sub_d    = 1'b0;
      neg_d       = 1'b0;
      right_vld_d = 1'b0;
    end else if (state_q == S_CALC) begin
      // key_ready is low here, so no key competes with the result load.
      tens_d  = au_tens_s;
      ones_d  = au_ones_s;
      neg_d   = au_neg_s;
      state_d = S_SHOW;
    end else if (accept_s) begin
      case (state_q)
        S_LEFT: begin
          if (key_digit_s) begin
            left_d  = key_code[3:0];
            state_d = S_OP;
          end else begin
            state_d = S_LEFT;
          end
        end
        S_OP: begin
          if (key_digit_s) begin
            left_d = key_code[3:0];
          end else if (key_add_s || key_sub_s) begin
            op_sub_d    = key_sub_s;
            right_vld_d = 1'b0;
            state_d     = S_RIGHT;
          end else begin
            state_d = S_OP;
          end
        end
        S_RIGHT: begin
          if (key_digit_s) begin
            right_d     = key_code[3:0];
            right_vld_d = 1'b1;
          end else if (key_add_s || key_sub_s) begin
            op_sub_d = key_sub_s;
          end else if (key_enter_s && right_vld_q) begin
            state_d = S_CALC;
          end else begin
            state_d = S_RIGHT;
          end
        end
        S_SHOW: begin
          if (key_digit_s) begin
            left_d      = key_code[3:0];
            right_d     = 4'd0;
            tens_d      = 4'd0;
            ones_d      = 4'd0;
            neg_d       = 1'b0;
            right_vld_d = 1'b0;
            state_d     = S_OP;
          end else begin
            state_d = S_SHOW;
          end
        end
        default: state_d = S_LEFT;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Display image derived from the current registers, with blanking.
  always_comb begin
    disp_d = {4{BLANK_CODE}};
    if (state_q != S_LEFT) begin
      disp_d[15:12] = left_q;
    end else begin
      disp_d[15:12] = BLANK_CODE;
    end
    if (right_vld_q) begin
      disp_d[11:8] = right_q;
    end else begin
      disp_d[11:8] = BLANK_CODE;
    end
    if (state_q == S_SHOW) begin
      disp_d[7:4] = (tens_q != 4'd0) ? tens_q : BLANK_CODE;
      disp_d[3:0] = ones_q;
    end else begin
      disp_d[7:0] = {2{BLANK_CODE}};
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LEFT;
      left_q      <= 4'd0;
      right_q     <= 4'd0;
      tens_q      <= 4'd0;
      ones_q      <= 4'd0;
      op_sub_q    <= 1'b0;
      neg_q       <= 1'b0;
      right_vld_q <= 1'b0;
      key_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      disp_q      <= {4{BLANK_CODE}};
    end else begin
      state_q     <= state_d;
      left_q      <= left_d;
      right_q     <= right_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      op_sub_q    <= op_sub_d;
      neg_q       <= neg_d;
      right_vld_q <= right_vld_d;
      key_ready_q <= (state_d != S_CALC);
      busy_q      <= (state_d == S_CALC);
      disp_q      <= disp_d;
    end
  end

  assign key_ready = key_ready_q;
  assign busy      = busy_q;
  assign disp      = disp_q;

endmodule

// File: tb/tb_calc_key_seq.sv
// tb_calc_key_seq -- directed scenarios plus randomized key streams for
// calc_key_seq, checked every cycle against a behavioural calculator model.
module tb_calc_key_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_ready, neg, busy;
  logic [15:0] disp;

  calc_key_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .disp      (disp),
    .neg       (neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

`ifdef CALC_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  localparam int P_LEFT = 0, P_OP = 1, P_RIGHT = 2, P_CALC = 3, P_SHOW = 4;

  int checks   = 0;
  int failures = 0;
  int busy_cnt = 0;

  // Calculator model: phase, operands, pending op and signed integer result.
  int          m_phase, m_left, m_right, m_res;
  bit          m_rvld, m_sub;
  logic [15:0] exp_disp;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_phase = P_LEFT; m_left = 0; m_right = 0; m_res = 0;
    m_rvld = 1'b0; m_sub = 1'b0;
    exp_disp = 16'hFFFF;
  endfunction

  function automatic logic [15:0] m_view();
    int mag;
    logic [15:0] v;
    v = 16'hFFFF;
    if (m_phase != P_LEFT) v[15:12] = 4'(m_left);
    if (m_rvld) v[11:8] = 4'(m_right);
    if (m_phase == P_SHOW) begin
      mag = (m_res < 0) ? -m_res : m_res;
      if (mag / 10 != 0) v[7:4] = 4'(mag / 10);
      v[3:0] = 4'(mag % 10);
    end
    return v;
  endfunction

  // One clock edge of the calculator; returns whether the key was taken.
  function automatic bit m_edge(input bit v, input logic [3:0] k);
    bit acc, dig, addk, subk, ent, clr;
    int kv;
    kv   = int'(k);
    exp_disp = m_view();
    acc  = v && (m_phase != P_CALC);
    dig  = kv < 10;
    addk = kv == 10;
    subk = SUB_EN && kv == 11;
    ent  = kv == 12;
    clr  = kv == 13;
    if (acc && clr) begin
      m_phase = P_LEFT; m_left = 0; m_right = 0; m_res = 0; m_rvld = 1'b0; m_sub = 1'b0;
    end else if (m_phase == P_CALC) begin
      m_res   = m_sub ? (m_left - m_right) : (m_left + m_right);
      m_phase = P_SHOW;
    end else if (acc) begin
      if (m_phase == P_LEFT && dig) begin
        m_left = kv; m_phase = P_OP;
      end else if (m_phase == P_OP && dig) begin
        m_left = kv;
      end else if (m_phase == P_OP && (addk || subk)) begin
        m_sub = subk; m_rvld = 1'b0; m_phase = P_RIGHT;
      end else if (m_phase == P_RIGHT && dig) begin
        m_right = kv; m_rvld = 1'b1;
      end else if (m_phase == P_RIGHT && (addk || subk)) begin
        m_sub = subk;
      end else if (m_phase == P_RIGHT && ent && m_rvld) begin
        m_phase = P_CALC;
      end else if (m_phase == P_SHOW && dig) begin
        m_left = kv; m_right = 0; m_res = 0; m_rvld = 1'b0; m_phase = P_OP;
      end
    end
    return acc;
  endfunction

  task automatic step(input bit v, input logic [3:0] k, output bit acc);
    key_valid = v;
    key_code  = k;
    @(posedge clk);
    acc = m_edge(v, k);
    #1;
    if (busy === 1'b1) busy_cnt++;
    chk("disp",  32'(disp),      32'(exp_disp));
    chk("neg",   32'(neg),       32'(m_res < 0));
    chk("busy",  32'(busy),      32'(m_phase == P_CALC));
    chk("ready", 32'(key_ready), 32'(m_phase != P_CALC));
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, acc);
  endtask

  // Source holds the key until taken; bounded to catch a stuck key_ready.
  task automatic press(input logic [3:0] k);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 4 && !acc; t++) step(1'b1, k, acc);
    if (!acc) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic keys(input logic [3:0] seq[$]);
    foreach (seq[i]) press(seq[i]);
  endtask

  initial begin
    bit acc;
    logic [3:0] k;
    rst_n = 1'b0; key_valid = 1'b0; key_code = 4'h0;
    m_reset();
    #12;
    chk("rst_disp",  32'(disp),      32'h0000FFFF);
    chk("rst_ready", 32'(key_ready), 32'd1);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_neg",   32'(neg),       32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 7 + 8 = 15, busy for exactly one cycle
    busy_cnt = 0;
    keys('{4'h7, 4'hA, 4'h8, 4'hC});
    idle(2);
    chk("add_7_8",   32'(disp),     32'h00007815);
    chk("busy_once", 32'(busy_cnt), 32'd1);

    // left digit overwritten in S_OP, tens blanked
    keys('{4'hD, 4'h3, 4'h5, 4'hA, 4'h4, 4'hC});
    idle(2);
    chk("add_5_4", 32'(disp), 32'h000054F9);

    if (SUB_EN) begin
      keys('{4'hD, 4'h2, 4'hB, 4'h9, 4'hC});
      idle(2);
      chk("sub_2_9",     32'(disp), 32'h000029F7);
      chk("sub_2_9_neg", 32'(neg),  32'd1);
      keys('{4'hD, 4'h4, 4'hB, 4'h4, 4'hC});
      idle(2);
      chk("sub_4_4",     32'(disp), 32'h000044F0);
      chk("sub_4_4_neg", 32'(neg),  32'd0);
    end else begin
      keys('{4'hD, 4'h2, 4'hB});
      idle(1);
      chk("sub_ignored", 32'(disp), 32'h00002FFF);
    end

    // key held through S_CALC is taken on the following cycle
    keys('{4'hD, 4'h1, 4'hA, 4'h2, 4'hC, 4'h1});
    idle(1);
    chk("held_key", 32'(disp), 32'h00001FFF);

    // clear, then ignored keys in S_LEFT
    keys('{4'hD, 4'h9, 4'hA, 4'hD});
    idle(1);
    chk("clear", 32'(disp), 32'h0000FFFF);
    keys('{4'hC, 4'hE, 4'hF, 4'hA});
    idle(1);
    chk("left_ignore", 32'(disp), 32'h0000FFFF);

    // asynchronous reset in the middle of S_CALC
    keys('{4'h3, 4'hA, 4'h4, 4'hC});
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_disp",  32'(disp),      32'h0000FFFF);
    chk("arst_busy",  32'(busy),      32'd0);
    chk("arst_ready", 32'(key_ready), 32'd1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    chk("arst_after", 32'(disp), 32'h0000FFFF);

    // randomized key streams
    for (int n = 0; n < 800; n++) begin
      k = 4'($urandom_range(0, 15));
      if (k == 4'hD && $urandom_range(0, 3) != 0) k = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) k = 4'hC;
      press(k);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    step(1'b0, 4'h0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
